coin_feeder: RTL



---
 rtl/vend_pkg.sv | 14 +
 rtl/coin_feeder_if.sv | 23 ++
 rtl/pulse_spacer.sv | 27 ++
 rtl/coin_feeder.sv | 106 ++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending constants and FSM state encodings
package vend_pkg;
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_INSERT    = 5'b00010,
        ST_GAP       = 5'b00100,
        ST_WAIT_COLA = 5'b01000,
        ST_FINISH    = 5'b10000
    } vend_state_t;

    localparam int PRICE_DEFAULT = 3;
    localparam int PULSE_WIDTH   = 1;
    localparam int CNT_W         = 4;
endpackage

// File: rtl/coin_feeder_if.sv
// rtl/coin_feeder_if.sv - command/status and vending coin interface bundle
interface coin_feeder_if;
    import vend_pkg::*;

    logic             buy_req;
    logic [CNT_W-1:0] buy_num;
    logic             po_cola;
    logic             pi_money;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cola_cnt;

    modport master (
        output buy_req, buy_num, po_cola,
        input  pi_money, busy, done, err, cola_cnt
    );

    modport slave (
        input  buy_req, buy_num, po_cola,
        output pi_money, busy, done, err, cola_cnt
    );
endinterface

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - loadable down-counter flagging its final counted cycle
module pulse_spacer #(
    parameter int LOAD = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int W = $clog2(LOAD + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LOAD);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded on entry, so the LOAD-th cycle in the timed state sees cnt == 1.
    assign last = (cnt == W'(1));
endmodule

// File: rtl/coin_feeder.sv
// rtl/coin_feeder.sv - drives coin pulses into the vending FSM and collects colas
module coin_feeder
    import vend_pkg::*;
#(
    parameter int PRICE   = PRICE_DEFAULT,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    coin_feeder_if.slave  bus
);
    localparam int CW = $clog2(PRICE + 1);

    vend_state_t      state, state_next;
    logic [CW-1:0]    coin_cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cola_q;
    logic             pi_money_q, busy_q, done_q, err_q;
    logic             gap_last, tmo_last;
    logic             in_txn;

    assign in_txn = (state == ST_INSERT) || (state == ST_GAP) || (state == ST_WAIT_COLA);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:
                if (bus.buy_req) state_next = (bus.buy_num != '0) ? ST_INSERT : ST_FINISH;
            ST_INSERT:
                state_next = (coin_cnt == CW'(PRICE - 1)) ? ST_WAIT_COLA : ST_GAP;
            ST_GAP:
                if (gap_last) state_next = ST_INSERT;
            ST_WAIT_COLA:
                if (bus.po_cola)
                    state_next = ((cola_q + 4'd1) == target) ? ST_FINISH : ST_GAP;
                else if (tmo_last)
                    state_next = ST_FINISH;
            ST_FINISH:
                state_next = ST_IDLE;
            default:
                state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            coin_cnt   <= '0;
            target     <= '0;
            cola_q     <= '0;
            err_q      <= 1'b0;
            pi_money_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (bus.buy_req) begin
                        target   <= bus.buy_num;
                        cola_q   <= '0;
                        err_q    <= 1'b0;
                        coin_cnt <= '0;
                    end
                ST_INSERT:
                    coin_cnt <= (coin_cnt == CW'(PRICE - 1)) ? '0 : coin_cnt + 1'b1;
                ST_WAIT_COLA:
                    if (bus.po_cola)  cola_q <= cola_q + 4'd1;
                    else if (tmo_last) err_q <= 1'b1;
                default: ;
            endcase
            if (in_txn && state != ST_WAIT_COLA && bus.po_cola) err_q <= 1'b1;
            pi_money_q <= (state_next == ST_INSERT);
            busy_q     <= (state_next == ST_INSERT) || (state_next == ST_GAP) ||
                          (state_next == ST_WAIT_COLA);
            done_q     <= (state_next == ST_FINISH);
        end
    end

    pulse_spacer #(.LOAD(GAP)) gap_timer (
        .clk    (sys_clk),
        .resetn (sys_rst_n),
        .load   (state_next == ST_GAP && state != ST_GAP),
        .en     (state == ST_GAP),
        .last   (gap_last)
    );

    pulse_spacer #(.LOAD(TIMEOUT)) tmo_timer (
        .clk    (sys_clk),
        .resetn (sys_rst_n),
        .load   (state_next == ST_WAIT_COLA && state != ST_WAIT_COLA),
        .en     (state == ST_WAIT_COLA),
        .last   (tmo_last)
    );

    assign bus.pi_money = pi_money_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cola_cnt = cola_q;
endmodule
